// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the instruction fetch path: FSM state encoding,
// PC step size and default reset vector.
package cpu_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_REQ     = 2'd1,
    FETCH_DELIVER = 2'd2
  } fetch_state_t;

  localparam int          PC_INCREMENT     = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: async reset to RESET_PC, word-aligned load and
// sequential +4 advance. Load and increment are mutually exclusive by design.
module pc_reg
  import cpu_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_val,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] pc
);

  function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] v);
    return v & ~ADDR_WIDTH'(3);
  endfunction

  // Increment wraps modulo 2^ADDR_WIDTH through natural truncation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= word_align(load_val);
    end else if (inc) begin
      pc <= pc + ADDR_WIDTH'(PC_INCREMENT);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a req/ack memory port and
// strobes IRWre for one cycle per word. Optional timeout via FETCH_TIMEOUT_EN.
module instr_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = ADDR_WIDTH'(RESET_PC_DEFAULT),
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FetchStart,
  input  logic                  PCWre,
  input  logic [ADDR_WIDTH-1:0] NextPC,
  output logic                  ImemReq,
  output logic [ADDR_WIDTH-1:0] ImemAddr,
  input  logic                  ImemAck,
  input  logic [DATA_WIDTH-1:0] ImemData,
  output logic                  IRWre,
  output logic [DATA_WIDTH-1:0] InstructionOut,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic                  Busy,
  output logic                  Fault
);

  fetch_state_t state;
  logic         pc_load;
  logic         pc_inc;
  logic         timeout_hit;

  // PC loads only while idle, so a same-cycle FetchStart uses the new value.
  assign pc_load  = (state == FETCH_IDLE) && PCWre;
  assign pc_inc   = (state == FETCH_DELIVER);
  assign ImemAddr = PC;

  pc_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_reg (
    .clk      (CLK),
    .rst      (RST),
    .load     (pc_load),
    .load_val (NextPC),
    .inc      (pc_inc),
    .pc       (PC)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Counts ack-less REQ cycles; the limit-th such cycle triggers the timeout.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_cnt <= '0;
    end else if (state == FETCH_IDLE && FetchStart) begin
      wait_cnt <= '0;
    end else if (state == FETCH_REQ && !ImemAck) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timeout_hit = (state == FETCH_REQ) && !ImemAck &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES < 1);
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= FETCH_IDLE;
      ImemReq        <= 1'b0;
      IRWre          <= 1'b0;
      Busy           <= 1'b0;
      Fault          <= 1'b0;
      InstructionOut <= '0;
    end else begin
      case (state)
        FETCH_IDLE: begin
          if (FetchStart) begin
            state   <= FETCH_REQ;
            ImemReq <= 1'b1;
            Busy    <= 1'b1;
          end
        end
        FETCH_REQ: begin
          // An ack arriving on the limit cycle still completes the fetch.
          if (ImemAck) begin
            InstructionOut <= ImemData;
            state          <= FETCH_DELIVER;
            ImemReq        <= 1'b0;
            IRWre          <= 1'b1;
          end else if (timeout_hit) begin
            state   <= FETCH_IDLE;
            ImemReq <= 1'b0;
            Busy    <= 1'b0;
            Fault   <= 1'b1;
          end
        end
        FETCH_DELIVER: begin
          state <= FETCH_IDLE;
          IRWre <= 1'b0;
          Busy  <= 1'b0;
        end
        default: begin
          state   <= FETCH_IDLE;
          ImemReq <= 1'b0;
          IRWre   <= 1'b0;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a queue scoreboard of expected
// (address, instruction) pairs checked whenever IRWre fires.
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        FetchStart = 1'b0;
  logic        PCWre = 1'b0;
  logic [31:0] NextPC = '0;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck = 1'b0;
  logic [31:0] ImemData = '0;
  logic        IRWre;
  logic [31:0] InstructionOut;
  logic [31:0] PC;
  logic        Busy;
  logic        Fault;

  int vectors     = 0;
  int miscompares = 0;
  int pulses_seen = 0;
  int pulses_exp  = 0;
  logic exp_fault = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } sb_entry_t;
  sb_entry_t sb_q[$];

  instr_fetch_unit #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .FetchStart     (FetchStart),
    .PCWre          (PCWre),
    .NextPC         (NextPC),
    .ImemReq        (ImemReq),
    .ImemAddr       (ImemAddr),
    .ImemAck        (ImemAck),
    .ImemData       (ImemData),
    .IRWre          (IRWre),
    .InstructionOut (InstructionOut),
    .PC             (PC),
    .Busy           (Busy),
    .Fault          (Fault)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each IRWre strobe must match the oldest outstanding fetch.
  always @(negedge CLK) begin
    if (!RST && IRWre === 1'b1) begin
      sb_entry_t e;
      pulses_seen++;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_irwre", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_instr", InstructionOut, e.data);
        chk("sb_pc_at_deliver", PC, e.addr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic fetch(input logic do_load, input logic [31:0] npc,
                       input logic [31:0] exp_addr, input logic [31:0] data,
                       input int delay, input logic disturb);
    sb_entry_t e;
    e.addr = exp_addr;
    e.data = data;
    sb_q.push_back(e);
    pulses_exp++;
    FetchStart = 1'b1;
    PCWre      = do_load;
    NextPC     = npc;
    @(negedge CLK);
    FetchStart = 1'b0;
    PCWre      = 1'b0;
    chk("req_high", ImemReq, 1);
    chk("req_addr", ImemAddr, exp_addr);
    chk("busy_req", Busy, 1);
    for (int i = 0; i < delay; i++) begin
      ImemAck  = 1'b0;
      ImemData = $urandom;
      FetchStart = (disturb && i == 0);
      PCWre      = (disturb && i == 0);
      NextPC     = 32'h0000_0500;
      @(negedge CLK);
      chk("wait_req_held", ImemReq, 1);
      chk("wait_addr_held", ImemAddr, exp_addr);
      chk("wait_no_irwre", IRWre, 0);
    end
    FetchStart = 1'b0;
    PCWre      = 1'b0;
    ImemData   = data;
    ImemAck    = 1'b1;
    @(negedge CLK);
    ImemAck  = 1'b0;
    ImemData = 32'hDEAD_BEEF;
    chk("deliver_irwre", IRWre, 1);
    chk("deliver_req_low", ImemReq, 0);
    chk("deliver_instr", InstructionOut, data);
    FetchStart = disturb;
    PCWre      = disturb;
    NextPC     = 32'h0000_0700;
    @(negedge CLK);
    FetchStart = 1'b0;
    PCWre      = 1'b0;
    chk("post_irwre_low", IRWre, 0);
    chk("post_busy_low", Busy, 0);
    chk("post_pc_inc", PC, exp_addr + 32'd4);
    chk("post_instr_hold", InstructionOut, data);
    chk("post_fault", Fault, exp_fault);
    @(negedge CLK);
    chk("post_no_second_req", ImemReq, 0);
    chk("post_pc_stable", PC, exp_addr + 32'd4);
  endtask

  initial begin
    @(negedge CLK);
    chk("rst_pc", PC, 32'h0);
    chk("rst_req", ImemReq, 0);
    chk("rst_irwre", IRWre, 0);
    chk("rst_instr", InstructionOut, 32'h0);
    chk("rst_busy", Busy, 0);
    chk("rst_fault", Fault, 0);
    RST = 1'b0;
    @(negedge CLK);

    fetch(1'b0, 32'h0, 32'h0000_0000, 32'h2001_0005, 0, 1'b0);
    fetch(1'b0, 32'h0, 32'h0000_0004, 32'h8C22_0004, 5, 1'b0);
    fetch(1'b1, 32'h0000_0103, 32'h0000_0100, 32'h0022_1820, 1, 1'b0);
    fetch(1'b0, 32'h0, 32'h0000_0104, 32'h1000_0003, 3, 1'b1);
    fetch(1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'hAC01_0008, 2, 1'b0);

    // Abort a fetch with reset while the request is outstanding.
    NextPC = 32'h0000_0040;
    PCWre = 1'b1;
    FetchStart = 1'b1;
    @(negedge CLK);
    PCWre = 1'b0;
    FetchStart = 1'b0;
    chk("abort_req_before", ImemReq, 1);
    chk("abort_addr_before", ImemAddr, 32'h0000_0040);
    RST = 1'b1;
    #1;
    chk("abort_req_dropped", ImemReq, 0);
    chk("abort_busy_dropped", Busy, 0);
    chk("abort_pc_reset", PC, 32'h0);
    chk("abort_instr_reset", InstructionOut, 32'h0);
    ImemAck  = 1'b1;
    ImemData = 32'h5555_AAAA;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("stray_ack_no_irwre", IRWre, 0);
    chk("stray_ack_no_capture", InstructionOut, 32'h0);
    chk("stray_ack_no_req", ImemReq, 0);
    ImemAck = 1'b0;
    @(negedge CLK);

`ifdef FETCH_TIMEOUT_EN
    FetchStart = 1'b1;
    @(negedge CLK);
    FetchStart = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_req_held", ImemReq, 1);
      chk("to_fault_low", Fault, 0);
      @(negedge CLK);
    end
    chk("to_req_dropped", ImemReq, 0);
    chk("to_fault_set", Fault, 1);
    chk("to_pc_unchanged", PC, 32'h0);
    chk("to_instr_unchanged", InstructionOut, 32'h0);
    chk("to_no_irwre", IRWre, 0);
    chk("to_busy_low", Busy, 0);
    exp_fault = 1'b1;
    @(negedge CLK);
    chk("to_fault_sticky", Fault, 1);
    fetch(1'b0, 32'h0, 32'h0000_0000, 32'h1234_5678, 3, 1'b0);
`else
    FetchStart = 1'b1;
    @(negedge CLK);
    FetchStart = 1'b0;
    for (int i = 0; i < 20; i++) @(negedge CLK);
    chk("nt_req_waits", ImemReq, 1);
    chk("nt_fault_zero", Fault, 0);
    sb_q.push_back('{addr: 32'h0, data: 32'h1234_5678});
    pulses_exp++;
    ImemData = 32'h1234_5678;
    ImemAck  = 1'b1;
    @(negedge CLK);
    ImemAck = 1'b0;
    chk("nt_deliver", IRWre, 1);
    @(negedge CLK);
    chk("nt_pc", PC, 32'h4);
`endif

    @(negedge CLK);
    chk("sb_pulse_count", pulses_seen, pulses_exp);
    chk("sb_queue_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
